// File: rtl/key_matrix_scan_pkg.sv
// rtl/key_matrix_scan_pkg.sv - shared constants, FSM states and helpers for the key matrix scanner
// Contents:
//   KEY_ROWS / KEY_COLS / KEY_NUM  matrix geometry
//   scan_state_e                   scanner FSM states
//   col_pattern()                  one-hot-low column drive for a column index
//   lowest_set()                   index of the lowest set bit of a key vector
package key_matrix_scan_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;
  localparam int KEY_NUM  = KEY_ROWS * KEY_COLS;

  typedef enum logic [1:0] {
    S_DRIVE   = 2'd0,
    S_SAMPLE  = 2'd1,
    S_COMPARE = 2'd2
  } scan_state_e;

  function automatic logic [3:0] col_pattern(input logic [1:0] col);
    logic [3:0] pat;
    case (col)
      2'd0:    pat = 4'b1110;
      2'd1:    pat = 4'b1101;
      2'd2:    pat = 4'b1011;
      default: pat = 4'b0111;
    endcase
    return pat;
  endfunction

  // Walks from the top down so the last hit is the lowest index.
  function automatic logic [3:0] lowest_set(input logic [KEY_NUM-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_frame_debounce.sv
// rtl/key_frame_debounce.sv - whole-frame debouncer for the 16-key matrix
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   frame_i        freshly scanned 16-key frame (1 = pressed)
//   compare_i      one-cycle strobe: frame_i is complete, evaluate it
//   accepted_o     last frame that was stable for DEBOUNCE_FRAMES frames
//   new_o          keys set in the newly accepted frame but not in the previous one
//   accept_o       one-cycle strobe in the cycle after an accepting compare
module key_frame_debounce
  import key_matrix_scan_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [KEY_NUM-1:0] frame_i,
  input  logic               compare_i,
  output logic [KEY_NUM-1:0] accepted_o,
  output logic [KEY_NUM-1:0] new_o,
  output logic               accept_o
);

  logic [KEY_NUM-1:0] last_q, last_d;
  logic [KEY_NUM-1:0] acc_q, acc_d;
  logic [KEY_NUM-1:0] new_q, new_d;
  logic [3:0]         stable_q, stable_d;
  logic [3:0]         stable_inc;
  logic               accept_q, accept_d;

  always_comb begin
    last_d     = last_q;
    acc_d      = acc_q;
    new_d      = new_q;
    stable_d   = stable_q;
    accept_d   = 1'b0;
    stable_inc = stable_q + 4'd1;
    if (compare_i) begin
      if (frame_i != last_q) begin
        last_d   = frame_i;
        stable_d = 4'd1;
      end else if (stable_q < 4'(DEBOUNCE_FRAMES)) begin
        stable_d = stable_inc;
        // Acceptance fires only on the exact crossing; once saturated the
        // count stays put so a held combination is never re-reported.
        if (stable_inc == 4'(DEBOUNCE_FRAMES)) begin
          acc_d    = frame_i;
          new_d    = frame_i & ~acc_q;
          accept_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q   <= '0;
      acc_q    <= '0;
      new_q    <= '0;
      stable_q <= 4'd0;
      accept_q <= 1'b0;
    end else begin
      last_q   <= last_d;
      acc_q    <= acc_d;
      new_q    <= new_d;
      stable_q <= stable_d;
      accept_q <= accept_d;
    end
  end

  assign accepted_o = acc_q;
  assign new_o      = new_q;
  assign accept_o   = accept_q;

endmodule

// File: rtl/key_matrix_scan.sv
// rtl/key_matrix_scan.sv - 4x4 key matrix scanner with frame debounce and key-code report
// Ports:
//   CLK          system clock
//   RST          synchronous active-high reset
//   Key_Row_In   active-low row lines, asynchronous to CLK
//   Key_Col_Out  one-hot-low column drive (4'b1110 = column 0)
//   Key_Code     col*4+row of the last reported key, held between reports
//   Key_Valid    one-cycle strobe, Key_Code is new in the same cycle
//   Key_Any      at least one key set in the debounced frame
module key_matrix_scan
  import key_matrix_scan_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] Key_Row_In,
  output logic [3:0] Key_Col_Out,
  output logic [3:0] Key_Code,
  output logic       Key_Valid,
  output logic       Key_Any
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [KEY_ROWS-1:0] row_meta_q, row_sync_q;
  scan_state_e         state_q, state_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [1:0]          col_q, col_d;
  logic [KEY_NUM-1:0]  frame_q, frame_d;
  logic [3:0]          code_q;
  logic [KEY_NUM-1:0]  accepted, new_keys;
  logic                accept;

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    col_d   = col_q;
    frame_d = frame_q;
    case (state_q)
      S_DRIVE: begin
        if (dwell_q == DW'(SCAN_DIV - 1)) begin
          dwell_d = '0;
          state_d = S_SAMPLE;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      S_SAMPLE: begin
        for (int r = 0; r < KEY_ROWS; r++) begin
          frame_d[{col_q, 2'(r)}] = ~row_sync_q[r];
        end
        // The 2-bit index wraps 3 -> 0, which puts column 0 back on the
        // pins during the compare cycle.
        col_d   = col_q + 2'd1;
        state_d = (col_q == 2'(KEY_COLS - 1)) ? S_COMPARE : S_DRIVE;
      end
      S_COMPARE: state_d = S_DRIVE;
      default:   state_d = S_DRIVE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      state_q    <= S_DRIVE;
      dwell_q    <= '0;
      col_q      <= 2'd0;
      frame_q    <= '0;
      code_q     <= 4'd0;
    end else begin
      row_meta_q <= Key_Row_In;
      row_sync_q <= row_meta_q;
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      frame_q    <= frame_d;
      code_q     <= Key_Code;
    end
  end

  key_frame_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk_i     (CLK),
    .rst_i     (RST),
    .frame_i   (frame_q),
    .compare_i (state_q == S_COMPARE),
    .accepted_o(accepted),
    .new_o     (new_keys),
    .accept_o  (accept)
  );

  // Only the lowest newly pressed key is reported; the rest are dropped.
  assign Key_Valid   = accept & (|new_keys);
  assign Key_Code    = Key_Valid ? lowest_set(new_keys) : code_q;
  assign Key_Any     = |accepted;
  assign Key_Col_Out = col_pattern(col_q);

endmodule

// File: tb/tb_key_matrix_scan.sv
// tb/tb_key_matrix_scan.sv - self-checking bench for key_matrix_scan
module tb_key_matrix_scan;

  localparam int SD    = 4;
  localparam int DF    = 3;
  localparam int FRAME = 4 * (SD + 1) + 1;

  logic        CLK;
  logic        RST;
  logic [3:0]  Key_Row_In;
  logic [3:0]  Key_Col_Out;
  logic [3:0]  Key_Code;
  logic        Key_Valid;
  logic        Key_Any;
  logic [15:0] keys;

  int errors = 0;
  int checks = 0;
  int frame_no = 0;

  key_matrix_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Key_Row_In (Key_Row_In),
    .Key_Col_Out(Key_Col_Out),
    .Key_Code   (Key_Code),
    .Key_Valid  (Key_Valid),
    .Key_Any    (Key_Any)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb begin
    Key_Row_In = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!Key_Col_Out[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[c*4+r]) Key_Row_In[r] = 1'b0;
        end
      end
    end
  end

  // Reference model: history of whole frames since reset.
  logic [15:0] hist[$];
  logic [15:0] m_acc;
  int          m_code, m_any, m_pend;

  function automatic void model_reset();
    hist.delete();
    m_acc  = 16'h0;
    m_code = 0;
    m_any  = 0;
    m_pend = 0;
  endfunction

  function automatic void model_frame(input logic [15:0] f);
    int run;
    logic [15:0] nw;
    hist.push_back(f);
    if (hist.size() > DF + 1) void'(hist.pop_front());
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != f) break;
      run++;
    end
    m_pend = 0;
    if (run == DF) begin
      nw    = f & ~m_acc;
      m_acc = f;
      m_any = (f != 0) ? 1 : 0;
      if (nw != 0) begin
        m_pend = 1;
        for (int b = 15; b >= 0; b--) if (nw[b]) m_code = b;
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s frame=%0d got=%0d expected=%0d", name, frame_no, act, exp);
    end
  endtask

  function automatic int exp_col(input int c);
    logic [3:0] one;
    one = 4'h1;
    if (c == FRAME - 1) return 4'hE;
    return int'(4'hF ^ (one << (c / (SD + 1))));
  endfunction

  task automatic check_cycle(input int c);
    chk("col", int'(Key_Col_Out), exp_col(c));
    chk("valid", int'(Key_Valid), (c == 0) ? m_pend : 0);
    chk("code", int'(Key_Code), m_code);
    chk("any", int'(Key_Any), m_any);
  endtask

  task automatic run_frame(input logic [15:0] k);
    keys = k;
    for (int c = 0; c < FRAME; c++) begin
      check_cycle(c);
      @(posedge CLK); #1;
    end
    model_frame(k);
    frame_no++;
  endtask

  task automatic do_reset();
    RST  = 1'b1;
    keys = 16'h0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [15:0] k;
    int          v;
    int          code;
    int          any;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [15:0] k, input int v, input int code, input int any, input int n);
    vec_t e;
    e.k = k; e.v = v; e.code = code; e.any = any;
    for (int i = 0; i < n; i++) tbl.push_back(e);
  endfunction

  logic [15:0] cur;

  initial begin
    RST  = 1'b1;
    keys = 16'h0;
    // idle, single press held, release
    add(16'h0000, 0, 0, 0, 3);
    add(16'h0040, 0, 0, 0, 2); add(16'h0040, 1, 6, 1, 1); add(16'h0040, 0, 6, 1, 10);
    add(16'h0000, 0, 6, 1, 2); add(16'h0000, 0, 6, 0, 1);
    // bounce on key 9
    add(16'h0200, 0, 6, 0, 1); add(16'h0000, 0, 6, 0, 1);
    add(16'h0200, 0, 6, 0, 1); add(16'h0000, 0, 6, 0, 1);
    add(16'h0200, 0, 6, 0, 2); add(16'h0200, 1, 9, 1, 1);
    add(16'h0000, 0, 9, 1, 2); add(16'h0000, 0, 9, 0, 1);
    // keys 3 and 12 together, then release 3
    add(16'h1008, 0, 9, 0, 2); add(16'h1008, 1, 3, 1, 1);
    add(16'h1000, 0, 3, 1, 3);
    add(16'h0000, 0, 3, 1, 2); add(16'h0000, 0, 3, 0, 1);
    // press, release, re-press key 15
    add(16'h8000, 0, 3, 0, 2); add(16'h8000, 1, 15, 1, 1);
    add(16'h0000, 0, 15, 1, 2); add(16'h0000, 0, 15, 0, 1);
    add(16'h8000, 0, 15, 0, 2); add(16'h8000, 1, 15, 1, 1);

    do_reset();
    chk("rst_col", int'(Key_Col_Out), 14);
    chk("rst_valid", int'(Key_Valid), 0);
    chk("rst_code", int'(Key_Code), 0);
    chk("rst_any", int'(Key_Any), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      run_frame(tbl[i].k);
      chk("tbl_valid", int'(Key_Valid), tbl[i].v);
      chk("tbl_code", int'(Key_Code), tbl[i].code);
      chk("tbl_any", int'(Key_Any), tbl[i].any);
    end

    // Reset in the middle of column 2 with key 5 already reported.
    do_reset();
    for (int i = 0; i < 3; i++) run_frame(16'h0020);
    chk("k5_valid", int'(Key_Valid), 1);
    chk("k5_code", int'(Key_Code), 5);
    keys = 16'h0020;
    for (int c = 0; c < 12; c++) begin
      check_cycle(c);
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    chk("mid_rst_col", int'(Key_Col_Out), 14);
    chk("mid_rst_valid", int'(Key_Valid), 0);
    chk("mid_rst_code", int'(Key_Code), 0);
    chk("mid_rst_any", int'(Key_Any), 0);
    for (int i = 0; i < 3; i++) run_frame(16'h0020);
    chk("k5_again_valid", int'(Key_Valid), 1);
    chk("k5_again_code", int'(Key_Code), 5);
    run_frame(16'h0020);
    chk("k5_no_repeat", int'(Key_Valid), 0);

    // Randomized frames against the model.
    do_reset();
    cur = 16'h0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        cur = 16'($urandom) & 16'($urandom) & 16'($urandom);
        if ($urandom_range(0, 4) == 0) cur = 16'h0;
      end
      run_frame(cur);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
